sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Shares the single SRAM controller port between two requesters: port 0 is the MEM stage (data) and port 1 is the fetch/refill path.
- Sits between the MEM stage / cache controller and the SRAM controller.
- Latches one request at a time, drives the controller's enable/address/data until the controller signals completion, and returns a one-cycle done pulse with read data to the winning requester.
- Arbitration is round-robin; a watchdog aborts hung transactions.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, write-data width.
- LINE_W, 64, read-data width returned by the controller.
- TIMEOUT, 255, maximum cycles to wait for mem_ready; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- r0_re, r0_we  in  1 each  port-0 read/write request, level, held until r0_done.
- r0_addr  in  ADDR_W  port-0 address.
- r0_wdata  in  DATA_W  port-0 write data.
- r0_done  out  1  port-0 transaction-complete pulse.
- r1_re, r1_we, r1_addr, r1_wdata, r1_done  as port 0, for port 1.
- rdata  out  LINE_W  read data, valid in the done cycle.
- grant  out  2  one-hot owner of the SRAM port (bit0 = port 0, bit1 = port 1).
- busy  out  1  high while a transaction is outstanding.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- mem_re, mem_we  out  1 each  SRAM controller enables.
- mem_addr  out  ADDR_W  address to the SRAM controller.
- mem_wdata  out  DATA_W  write data to the SRAM controller.
- mem_ready  in  1  controller completion, one-cycle pulse.
- mem_rdata  in  LINE_W  controller read data, valid with mem_ready.

Behaviour:
- Reset (rst=0, async): state=IDLE, last-grant pointer=1 (so port 0 wins first); every output and internal register is 0.
- A requester is "pending" when its re or we is high. If both are high, the request is a write. An address with neither re nor we high is ignored.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if no request is pending, stay. If exactly one is pending, grant it. If both are pending, grant the port that was not granted last.
    - At the clock edge, latch addr, wdata and op into mem_addr, mem_wdata and mem_we/mem_re; set grant and busy; go to ACCESS.
    - Latency: request visible at edge t gives mem_re/mem_we high from t+1.
  - ACCESS: hold mem_* stable and clear the watchdog counter on entry.
    - On mem_ready: capture mem_rdata into rdata (writes capture it too, value unused), drop mem_re/mem_we, go to DONE.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT without mem_ready: drop the enables, pulse timeout_err, and go to DONE with rdata=0.
  - DONE: assert the granted port's rN_done for exactly one cycle, update the last-grant pointer, clear grant and busy, go to IDLE.
- Throughput: the minimum gap between successive grants is 3 cycles (grant, mem_ready, done). The requester must deassert or change its request in the cycle after done, otherwise it is re-arbitrated as a new request.
- Requester inputs are sampled only in IDLE. Changes to r*_addr/r*_wdata, or a dropped request, during ACCESS or DONE have no effect; the transaction completes and done still pulses.
- mem_ready arriving outside ACCESS is ignored. mem_ready arriving in the same cycle as timeout expiry counts as success and raises no error.
- rdata holds its value until the next capture. r0_done and r1_done are never high together. grant is never 2'b11.
- Reset asserted mid-transaction: immediate return to IDLE, mem_re/mem_we drop asynchronously, no done pulse, and the controller is expected to be reset by the same rst.

Test Plan:
1. Single read on port 0 (r0_re=1, r0_addr=0x0000_0404), controller answers mem_ready 4 cycles after mem_re with mem_rdata=0xDEADBEEF_01234567 -> grant=01 one cycle after the request; mem_addr=0x404, mem_re high for 4 cycles; r0_done pulses once with rdata=0xDEADBEEF_01234567; busy returns to 0.
2. Simultaneous requests: r0 write to 0x10 with data 0xA5 and r1 read of 0x20, both held, then the next pair -> grants go port 0, then port 1, then port 0, ...; mem_we=1/mem_wdata=0xA5 for port 0; r0_done and r1_done alternate and never coincide.
3. Port 1 only, back-to-back reads at 0x100 and 0x108 with the request held continuously -> two separate transactions spaced at least 3 cycles apart, both granted to port 1.
4. Request with re=we=1 on port 1 -> treated as a write: mem_we=1, mem_re=0.
5. TIMEOUT=8, controller never answers -> timeout_err pulses exactly 9 cycles after entering ACCESS (8 counted cycles plus the transition), r0_done pulses with rdata=0, and the arbiter then accepts a new request.
6. rst driven low 2 cycles into ACCESS -> mem_re, grant and busy go to 0 without a clock edge; no done pulse; after rst goes high a pending port-0 request is granted first.

Source files
------------

// File: rtl/sram_access_arbiter_if.sv
// Requester and SRAM-controller handshake bundle for sram_access_arbiter.
interface sram_access_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINE_W = 64
);
    logic              r0_re;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_done;
    logic              r1_re;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_done;
    logic [LINE_W-1:0] rdata;
    logic [1:0]        grant;
    logic              busy;
    logic              timeout_err;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  r0_re, r0_we, r0_addr, r0_wdata,
        input  r1_re, r1_we, r1_addr, r1_wdata,
        input  mem_ready, mem_rdata,
        output r0_done, r1_done, rdata, grant, busy, timeout_err,
        output mem_re, mem_we, mem_addr, mem_wdata
    );

    // Requester / controller environment side.
    modport master (
        output r0_re, r0_we, r0_addr, r0_wdata,
        output r1_re, r1_we, r1_addr, r1_wdata,
        output mem_ready, mem_rdata,
        input  r0_done, r1_done, rdata, grant, busy, timeout_err,
        input  mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port between the MEM stage
// (port 0) and the fetch/refill path (port 1), with a hung-access watchdog.
module sram_access_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LINE_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_access_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          WD_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              r0_done_q, r0_done_d;
    logic              r1_done_q, r1_done_d;
    logic              terr_q, terr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic pend0_c, pend1_c, pick1_c;

    // Request decode and round-robin pick: port 1 wins alone, or when both
    // are pending and port 0 was granted last.
    always_comb begin
        pend0_c = bus.r0_re | bus.r0_we;
        pend1_c = bus.r1_re | bus.r1_we;
        pick1_c = pend1_c & (~pend0_c | ~last_q);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        r0_done_d   = 1'b0;
        r1_done_d   = 1'b0;
        terr_d      = 1'b0;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (pend0_c | pend1_c) begin
                    grant_d     = pick1_c ? 2'b10 : 2'b01;
                    busy_d      = 1'b1;
                    mem_addr_d  = pick1_c ? bus.r1_addr : bus.r0_addr;
                    mem_wdata_d = pick1_c ? bus.r1_wdata : bus.r0_wdata;
                    mem_we_d    = pick1_c ? bus.r1_we : bus.r0_we;
                    mem_re_d    = ~mem_we_d;
                    cnt_d       = '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    rdata_d   = bus.mem_rdata;
                    mem_re_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    r0_done_d = grant_q[0];
                    r1_done_d = grant_q[1];
                    state_d   = DONE;
                end else if (WD_EN && (cnt_q == CNT_W'(TIMEOUT))) begin
                    rdata_d   = '0;
                    mem_re_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    terr_d    = 1'b1;
                    r0_done_d = grant_q[0];
                    r1_done_d = grant_q[1];
                    state_d   = DONE;
                end else if (WD_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                last_d  = grant_q[1];
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            r0_done_q   <= 1'b0;
            r1_done_q   <= 1'b0;
            terr_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            r0_done_q   <= r0_done_d;
            r1_done_q   <= r1_done_d;
            terr_q      <= terr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.mem_re      = mem_re_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.r0_done     = r0_done_q;
    assign bus.r1_done     = r1_done_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomized transaction-level bench for sram_access_arbiter (TIMEOUT = 8).
module tb_sram_access_arbiter;
    localparam int unsigned TMO = 8;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    bit   last_port;      // reference model: port granted most recently
    logic [63:0] rd_model;

    sram_access_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LINE_W(64)) bus ();

    sram_access_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .LINE_W (64),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Never both dones, never both grant bits.
    always @(negedge clk) begin
        if (rst) chk("exclusive", {62'd0, bus.r0_done & bus.r1_done, &bus.grant}, 64'd0);
    end

    function automatic req_t mk(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_t q;
        q.re = re; q.we = we; q.addr = a; q.wdata = d;
        return q;
    endfunction

    function automatic req_t none();
        return mk(1'b0, 1'b0, 32'd0, 32'd0);
    endfunction

    task automatic drive(input req_t q0, input req_t q1);
        bus.r0_re = q0.re; bus.r0_we = q0.we; bus.r0_addr = q0.addr; bus.r0_wdata = q0.wdata;
        bus.r1_re = q1.re; bus.r1_we = q1.we; bus.r1_addr = q1.addr; bus.r1_wdata = q1.wdata;
    endtask

    // One complete transaction from IDLE back to IDLE. The controller answers
    // in ACCESS cycle 'lat' (0-based); lat > TMO means it never answers.
    task automatic do_txn(input req_t q0, input req_t q1, input int lat, input logic [63:0] line);
        bit   p0, p1, w, ok;
        int   last_k;
        req_t qw;
        p0 = q0.re | q0.we;
        p1 = q1.re | q1.we;
        w  = (p0 && p1) ? ~last_port : p1;
        qw = w ? q1 : q0;
        ok = (lat <= int'(TMO));
        last_k = ok ? lat : int'(TMO);
        drive(q0, q1);
        @(posedge clk); #1;
        chk("grant", {62'd0, bus.grant}, w ? 64'd2 : 64'd1);
        chk("busy", {63'd0, bus.busy}, 64'd1);
        chk("mem_we", {63'd0, bus.mem_we}, {63'd0, qw.we});
        chk("mem_re", {63'd0, bus.mem_re}, {63'd0, ~qw.we});
        chk("mem_addr", {32'd0, bus.mem_addr}, {32'd0, qw.addr});
        chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, qw.wdata});
        // Requester inputs are ignored once granted.
        bus.r0_addr = $urandom; bus.r1_addr = $urandom;
        bus.r0_wdata = $urandom; bus.r1_wdata = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            bus.r0_re = 1'($urandom); bus.r0_we = 1'($urandom);
            bus.r1_re = 1'($urandom); bus.r1_we = 1'($urandom);
        end
        for (int k = 0; k <= last_k; k++) begin
            chk("en_hold", {62'd0, bus.mem_re, bus.mem_we}, {62'd0, ~qw.we, qw.we});
            chk("addr_hold", {32'd0, bus.mem_addr}, {32'd0, qw.addr});
            chk("no_early_done", {61'd0, bus.r0_done, bus.r1_done, bus.timeout_err}, 64'd0);
            if (ok && k == lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = line;
            end
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = {$urandom, $urandom};
        end
        rd_model = ok ? line : 64'd0;
        drive(none(), none());
        chk("done", {62'd0, bus.r1_done, bus.r0_done}, w ? 64'd2 : 64'd1);
        chk("timeout_err", {63'd0, bus.timeout_err}, {63'd0, ~ok});
        chk("rdata", bus.rdata, rd_model);
        chk("en_drop", {62'd0, bus.mem_re, bus.mem_we}, 64'd0);
        chk("busy_done", {63'd0, bus.busy}, 64'd1);
        // Stray completion outside ACCESS must be ignored.
        if ($urandom_range(0, 2) == 0) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        chk("idle", {59'd0, bus.r0_done, bus.r1_done, bus.timeout_err, bus.grant}, 64'd0);
        chk("busy_idle", {63'd0, bus.busy}, 64'd0);
        chk("rdata_hold", bus.rdata, rd_model);
        last_port = w;
    endtask

    function automatic req_t rnd_req(input bit pend);
        req_t q;
        int   op;
        op = $urandom_range(0, 2);
        q.re    = pend && (op != 1);
        q.we    = pend && (op != 0);
        q.addr  = $urandom;
        q.wdata = $urandom;
        return q;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_port = 1'b1;
        rd_model = 64'd0;
        rst = 1'b0;
        drive(none(), none());
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 64'd0;
        #12;
        chk("rst_outs", {54'd0, bus.grant, bus.busy, bus.timeout_err, bus.mem_re, bus.mem_we,
                         bus.r0_done, bus.r1_done, 2'b00}, 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_addr", {bus.mem_addr, bus.mem_wdata}, 64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Single read on port 0, answered in the 4th ACCESS cycle.
        do_txn(mk(1, 0, 32'h0000_0404, 32'd0), none(), 3, 64'hDEADBEEF_01234567);

        // Simultaneous requests alternate between the ports.
        for (int i = 0; i < 4; i++)
            do_txn(mk(0, 1, 32'h10, 32'hA5), mk(1, 0, 32'h20, 32'd0), 0, {$urandom, $urandom});

        // Port 1 held continuously: re-arbitrated three cycles after the first grant.
        drive(none(), mk(1, 0, 32'h100, 32'd0));
        @(posedge clk); #1;
        chk("bb_grant1", {62'd0, bus.grant}, 64'd2);
        chk("bb_addr1", {32'd0, bus.mem_addr}, 64'h100);
        bus.mem_ready = 1'b1; bus.mem_rdata = 64'h1111;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        chk("bb_done1", {62'd0, bus.r1_done, bus.r0_done}, 64'd2);
        bus.r1_addr = 32'h108;
        @(posedge clk); #1;
        chk("bb_gap", {62'd0, bus.grant}, 64'd0);
        @(posedge clk); #1;
        chk("bb_grant2", {62'd0, bus.grant}, 64'd2);
        chk("bb_addr2", {32'd0, bus.mem_addr}, 64'h108);
        drive(none(), none());
        bus.mem_ready = 1'b1; bus.mem_rdata = 64'h2222;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        chk("bb_done2", {62'd0, bus.r1_done, bus.r0_done}, 64'd2);
        chk("bb_rdata2", bus.rdata, 64'h2222);
        @(posedge clk); #1;
        last_port = 1'b1;
        rd_model = 64'h2222;

        // re and we together means write.
        do_txn(none(), mk(1, 1, 32'h300, 32'hCAFE), 1, 64'h5);

        // Watchdog: never answered, answered on the expiry cycle, one past it.
        do_txn(mk(1, 0, 32'h40, 32'd0), none(), 100, 64'h0);
        do_txn(mk(1, 0, 32'h44, 32'd0), none(), int'(TMO), 64'h0123_4567_89AB_CDEF);
        do_txn(none(), mk(0, 1, 32'h48, 32'h9), int'(TMO) + 1, 64'h77);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            do_txn(rnd_req(sel[0]), rnd_req(sel[1]), $urandom_range(0, 11), {$urandom, $urandom});
        end

        // Reset mid-ACCESS: set up so port 1 would win, then reset.
        do_txn(mk(1, 0, 32'h50, 32'd0), none(), 0, 64'h1);
        drive(mk(1, 0, 32'h60, 32'd0), mk(1, 0, 32'h70, 32'd0));
        @(posedge clk); #1;
        chk("pre_rst_grant", {62'd0, bus.grant}, 64'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        chk("arst_outs", {60'd0, bus.mem_re, bus.mem_we, bus.grant[1], bus.busy}, 64'd0);
        chk("arst_grant", {62'd0, bus.grant}, 64'd0);
        @(posedge clk); #1;
        chk("arst_nodone", {62'd0, bus.r0_done, bus.r1_done}, 64'd0);
        rst = 1'b1;
        last_port = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_grant", {62'd0, bus.grant}, 64'd1);
        chk("post_rst_addr", {32'd0, bus.mem_addr}, 64'h60);
        rst = 1'b0;
        drive(none(), none());
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("final_idle", {61'd0, bus.grant, bus.busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
